// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbStateT;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ownerT;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between I-cache and D-cache requests.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  iReq,
  input  logic  dReq,
  input  logic  grant,
  output ownerT pickOwner
);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starveCnt;
  logic             starved;

  assign starved = (starveCnt == CNT_W'(STARVE_LIMIT));

  // D wins a tie unless I has already watched STARVE_LIMIT D grants go by
  always_comb begin
    pickOwner = OWN_D;
    if (iReq && (!dReq || starved)) begin
      pickOwner = OWN_I;
    end else begin
      pickOwner = OWN_D;
    end
  end

  // Count consecutive D grants that were made while I was waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grant) begin
      if ((pickOwner == OWN_I) || !iReq) begin
        starveCnt <= '0;
      end else begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end
`else
  localparam int unusedLimit = STARVE_LIMIT;
  logic unusedInputs;

  assign unusedInputs = ^{clk, rst, grant};

  // Strict D priority
  always_comb begin
    pickOwner = OWN_D;
    if (iReq && !dReq) begin
      pickOwner = OWN_I;
    end else begin
      pickOwner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache engines.
// Starvation guard for I-cache is compiled in with ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arbStateT          stateR;
  ownerT             ownerR;
  ownerT             pickOwner;
  logic              anyReq;
  logic              grant;
  logic              selWr;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              finish;

  assign anyReq = i_req | d_req;
  assign grant  = (stateR == IDLE) && anyReq;
  assign finish = (stateR == WAIT) && mem_done;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uPick (
    .clk      (clk),
    .rst      (rst),
    .iReq     (i_req),
    .dReq     (d_req),
    .grant    (grant),
    .pickOwner(pickOwner)
  );

  // Issue operands of whichever requester is about to win
  always_comb begin
    selWr    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    if (pickOwner == OWN_I) begin
      selWr    = i_wr;
      selAddr  = i_addr;
      selWdata = i_wdata;
    end else begin
      selWr    = d_wr;
      selAddr  = d_addr;
      selWdata = d_wdata;
    end
  end

  // Transaction FSM; strobes and issue operands are captured at grant and held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR    <= IDLE;
      ownerR    <= OWN_D;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (anyReq) begin
            stateR    <= ISSUE;
            ownerR    <= pickOwner;
            mem_rd    <= ~selWr;
            mem_wr    <= selWr;
            mem_addr  <= selAddr;
            mem_wdata <= selWdata;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            stateR <= WAIT;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_done) begin
            stateR <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          stateR <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Completion is reported in the very cycle memory signals it
  assign i_done  = finish && (ownerR == OWN_I);
  assign d_done  = finish && (ownerR == OWN_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand-written corner sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_done, d_done;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_done;
  logic [15:0] mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iReq, dReq, wr;
    logic [15:0] iAddr, dAddr, iWdata, dWdata;
    int          stall, lat;
    logic [15:0] rdata;
    logic        expRd, expWr;
    logic [15:0] expAddr, expWdata;
    logic        expI, expD;
    int          expStrobe;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic runTxn(input vec_t v);
    int          strobeCnt;
    logic        unstable;
    logic [15:0] a0, w0;
    i_req = v.iReq; d_req = v.dReq; i_wr = v.wr; d_wr = v.wr;
    i_addr = v.iAddr; d_addr = v.dAddr; i_wdata = v.iWdata; d_wdata = v.dWdata;
    mem_stall = (v.stall != 0);
    @(posedge clk); #1;
    chk("issueRd", mem_rd, v.expRd);
    chk("issueWr", mem_wr, v.expWr);
    chk("issueAddr", mem_addr, v.expAddr);
    chk("issueWdata", mem_wdata, v.expWdata);
    chk("issueBusy", busy, 1);
    a0 = mem_addr; w0 = mem_wdata; strobeCnt = 0; unstable = 1'b0;
    while ((mem_rd | mem_wr) && strobeCnt < 20) begin
      strobeCnt++;
      if (strobeCnt > v.stall) mem_stall = 1'b0;
      @(posedge clk); #1;
      if ((mem_rd | mem_wr) && (mem_addr != a0 || mem_wdata != w0)) unstable = 1'b1;
    end
    mem_stall = 1'b0;
    chk("strobeCycles", strobeCnt, v.expStrobe);
    chk("stallStable", unstable, 0);
    chk("waitNoStrobe", mem_rd | mem_wr, 0);
    repeat (v.lat) begin
      chk("earlyDone", i_done | d_done, 0);
      @(posedge clk); #1;
    end
    mem_done = 1'b1; mem_rdata = v.rdata;
    #1;
    chk("iDone", i_done, v.expI);
    chk("dDone", d_done, v.expD);
    if (v.expI) chk("iRdata", i_rdata, v.rdata);
    else        chk("dRdata", d_rdata, v.rdata);
    @(posedge clk); #1;
    mem_done = 1'b0; i_req = 1'b0; d_req = 1'b0;
    chk("idleAfter", busy, 0);
    chk("donePulseEnds", i_done | d_done, 0);
  endtask

  // Grant one transaction with both addresses distinct; report whether I won
  task automatic grantOne(output logic isI);
    @(posedge clk); #1;
    isI = (mem_addr == 16'h0100);
    chk("guardIssue", mem_rd, 1);
    @(posedge clk); #1;
    mem_done = 1'b1; mem_rdata = 16'h0C0C;
    #1;
    chk("guardDone", isI ? i_done : d_done, 1);
    chk("guardOtherDone", isI ? d_done : i_done, 0);
    @(posedge clk); #1;
    mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic isI;
    logic expSeq[6];
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0A0A, 16'h0000, 0, 2, 16'hBEEF,
                1'b1, 1'b0, 16'h1234, 16'h0A0A, 1'b1, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0111, 16'h0040, 16'h5A5A, 16'hA5A5, 2, 1, 16'h0000,
                1'b0, 1'b1, 16'h0040, 16'hA5A5, 1'b0, 1'b1, 3};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 16'h1357,
                1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0F0F, 16'hFFFF, 16'h00FF, 1, 3, 16'h0000,
                1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 16'h0001, 16'h0002, 3, 1, 16'h8001,
                1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 4};

`ifdef ARB_STARVE_GUARD_EN
    expSeq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    expSeq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset values, with a stray mem_done present during reset
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_wr = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; i_wdata = 16'h0; d_wdata = 16'h0;
    mem_stall = 1'b0; mem_done = 1'b1; mem_rdata = 16'h0;
    #1;
    chk("rstBusy", busy, 0);
    chk("rstStrobes", {mem_rd, mem_wr}, 0);
    chk("rstDone", {i_done, d_done}, 0);
    @(posedge clk); #1;
    mem_done = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) runTxn(vecs[k]);

    // Simultaneous requests: D write first, I one IDLE cycle after d_done
    i_req = 1'b1; d_req = 1'b1; i_wr = 1'b0; d_wr = 1'b1;
    i_addr = 16'h0100; d_addr = 16'h0040; d_wdata = 16'h1111;
    @(posedge clk); #1;
    chk("simDWr", mem_wr, 1);
    chk("simDAddr", mem_addr, 16'h0040);
    @(posedge clk); #1;
    mem_done = 1'b1; mem_rdata = 16'h0;
    #1;
    chk("simDDone", d_done, 1);
    chk("simINotDone", i_done, 0);
    @(posedge clk); #1;
    mem_done = 1'b0; d_req = 1'b0;
    chk("simGapIdle", busy, 0);
    chk("simGapNoStrobe", mem_rd | mem_wr, 0);
    @(posedge clk); #1;
    chk("simIRd", mem_rd, 1);
    chk("simIAddr", mem_addr, 16'h0100);
    @(posedge clk); #1;
    mem_done = 1'b1; mem_rdata = 16'h2222;
    #1;
    chk("simIDone", i_done, 1);
    chk("simIRdata", i_rdata, 16'h2222);
    @(posedge clk); #1;
    mem_done = 1'b0; i_req = 1'b0;
    @(posedge clk); #1;

    // Both requests held: starvation guard pattern (or strict D priority)
    i_req = 1'b1; d_req = 1'b1; i_wr = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0100; d_addr = 16'h0200;
    for (int g = 0; g < 6; g++) begin
      grantOne(isI);
      chk($sformatf("grant%0d", g), isI, expSeq[g]);
    end
    d_req = 1'b0;
    grantOne(isI);
    chk("grantAfterDDrop", isI, 1);
    i_req = 1'b0;
    @(posedge clk); #1;

    // Reset in WAIT, then a late mem_done must be ignored
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("preRstBusy", busy, 1);
    #2; rst = 1'b1;
    #1;
    chk("asyncRstBusy", busy, 0);
    chk("asyncRstStrobes", {mem_rd, mem_wr}, 0);
    i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("lateDoneIgnored", {i_done, d_done}, 0);
    @(posedge clk); #1;
    chk("lateDoneState", busy, 0);
    mem_done = 1'b0;
    v = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0400, 16'h0000, 16'h0000, 0, 1, 16'h4242,
          1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b1, 1};
    runTxn(v);

    // mem_done while IDLE
    @(posedge clk); #1;
    mem_done = 1'b1;
    #1;
    chk("idleMemDone", {i_done, d_done}, 0);
    @(posedge clk); #1;
    chk("idleStays", busy, 0);
    chk("idleNoStrobe", mem_rd | mem_wr, 0);
    mem_done = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared main-memory port between the instruction-cache and data-cache miss/write-back engines. Each cache holds a level request until it receives a one-cycle done pulse; the arbiter owns the memory port for exactly one transaction at a time. D-cache has priority, and a starvation guard bounds how long I-cache waits. Sits between the two cache controllers and the banked main memory inside the processor's memory system.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting (used only with the guard compiled in; ≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req / d_req  in  1  level request; held until matching done
- i_wr / d_wr  in  1  1 = write, 0 = read; stable while req high
- i_addr / d_addr  in  ADDR_W  transaction address; stable while req high
- i_wdata / d_wdata  in  DATA_W  write data; stable while req high
- i_done / d_done  out  1  one-cycle completion pulse
- i_rdata / d_rdata  out  DATA_W  read data, valid only while matching done is high
- mem_rd / mem_wr  out  1  issue strobes to memory
- mem_addr  out  ADDR_W  issue address
- mem_wdata  out  DATA_W  issue write data
- mem_stall  in  1  memory cannot accept issue this cycle
- mem_done  in  1  memory completion pulse (reads and writes)
- mem_rdata  in  DATA_W  read data, valid with mem_done
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT; registered owner (I or D).
- IDLE: if any req, pick winner, latch owner, go ISSUE. No req: stay.
- Pick rule: only one requesting → that one. Both → D, unless the guard forces I (see Configuration).
- ISSUE: mem_rd = ~wr_owner, mem_wr = wr_owner; mem_addr/mem_wdata muxed from owner. mem_stall high → stay in ISSUE, strobe held. mem_stall low → go WAIT.
- WAIT: strobes low. On mem_done: owner's done = 1 (combinational), owner's rdata = mem_rdata, go IDLE.
- i_rdata/d_rdata = mem_rdata passthrough; value outside done is don't-care.
- mem_done in IDLE or ISSUE: ignored, no done pulse.
- Requester drops req at the edge where it samples done; arbiter re-arbitrates in the following IDLE cycle.
- A req that drops before done is a protocol violation; behaviour is undefined.

## Timing
- Reset values: state IDLE, owner D, starve count 0, mem_rd = mem_wr = 0, i_done = d_done = 0, busy = 0. rst takes effect asynchronously; strobes fall immediately.
- If req is high at edge N in IDLE, the strobe is asserted in cycle N+1. If there is no stall, the state is WAIT from N+2. Done occurs in the same cycle as mem_done.
- Minimum gap between back-to-back transactions: one IDLE cycle after done.
- Each stall cycle adds one cycle; mem_addr, mem_wdata, and the strobe are stable throughout a stall.
- Reset during ISSUE or WAIT: the transaction is abandoned, no done pulse, and a late mem_done is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined: a counter counts consecutive D grants made while i_req is high. When the counter equals STARVE_LIMIT and both request, I wins. The counter clears on any I grant, and also on any D grant made while i_req is low. Its width is $clog2(STARVE_LIMIT+1).
- ARB_STARVE_GUARD_EN undefined: strict D priority, no counter.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT), owner enum (OWN_I, OWN_D).
- Sub-module mem_arb_pick: combinational pick plus the starvation counter register. It is the only part affected by the macro.
- Top: FSM, owner register, issue mux, done/rdata steering.

## Test plan
- Single I read, mem_done 3 cycles after the strobe, mem_rdata = 16'hBEEF → exactly one i_done pulse with i_rdata = BEEF; d_done stays 0.
- i_req and d_req rise in the same cycle, D write to addr 16'h0040 → D is issued first, then I one IDLE cycle after d_done.
- mem_stall held for 2 cycles on a D write → mem_wr high for 3 cycles with constant addr/wdata; one d_done.
- Guard on, STARVE_LIMIT = 2, d_req held continuously plus i_req → grant sequence D, D, I, D, D, I. Guard off → D only until d_req drops.
- rst pulsed during WAIT, with a stray mem_done afterwards → all outputs at reset values, no done pulse; the next request proceeds normally.
- mem_done while IDLE → no done pulse, state unchanged.
